// File: rtl/async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO: depth derivation and Gray/binary conversion.
// Functions work on a maximum-width vector; callers zero-extend and truncate to their width.
package async_fifo_pkg;

    localparam int unsigned MinAddrSize = 2;
    localparam int unsigned MaxAddrSize = 16;
    localparam int unsigned MaxPtrW     = MaxAddrSize + 1;

    typedef logic [MaxPtrW-1:0] ptr_max_t;

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Zero upper bits leave the prefix XOR unaffected, so one width serves every pointer size.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[MaxPtrW-1] = gray[MaxPtrW-1];
        for (int i = MaxPtrW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write- and read-side pointer controllers.
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int unsigned Width = 5
) (
    input  logic [Width-1:0] gray,
    output logic [Width-1:0] bin
);

    if (Width < 1 || Width > MaxPtrW) begin : g_bad_width
        $error("gray2bin_conv: Width out of range");
    end

    always_comb begin
        bin = Width'(gray2bin(ptr_max_t'(gray)));
    end

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer and status controller for the asynchronous FIFO:
// binary RAM address, Gray pointer for the read side, full/almost-full, level/room, overflow.
module wr_ptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                wr_clk,
    input  logic                wrst,
    input  logic                wr_en,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   wr_afull_thresh,
    input  logic                wr_ovf_clr,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic                wr_push,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wr_full,
    output logic                wr_afull,
    output logic [ADDRSIZE:0]   wr_level,
    output logic [ADDRSIZE:0]   wr_room,
    output logic                wr_overflow
);

    localparam int unsigned Depth = fifo_depth(ADDRSIZE);
    localparam int unsigned PtrW  = ADDRSIZE + 1;

    if (ADDRSIZE < MinAddrSize || ADDRSIZE > MaxAddrSize) begin : g_bad_param
        $error("wr_ptr_ctrl: ADDRSIZE must be in 2..16");
    end

    logic [ADDRSIZE:0] wbin_q;
    logic [ADDRSIZE:0] wbin_d;
    logic [ADDRSIZE:0] wgray_d;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] full_cmp;
    logic [ADDRSIZE:0] level_d;
    logic [ADDRSIZE:0] room_d;
    logic              full_d;
    logic              afull_d;
    logic              ovf_d;

    gray2bin_conv #(
        .Width (PtrW)
    ) u_rptr_conv (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    assign wr_push = wr_en & ~wr_full;
    assign wr_addr = wbin_q[ADDRSIZE-1:0];

    always_comb begin
        wbin_d   = wbin_q + PtrW'(wr_push);
        wgray_d  = PtrW'(bin2gray(ptr_max_t'(wbin_d)));
        // Write pointer one lap ahead of the read pointer: top two Gray bits inverted.
        full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        full_d   = (wgray_d == full_cmp);
        // Modulo subtraction stays correct across pointer wrap; stale rptr only over-reports.
        level_d  = wbin_d - rbin;
        room_d   = PtrW'(Depth) - level_d;
        afull_d  = (level_d >= wr_afull_thresh);
        // A blocked write sets the flag even when a clear arrives in the same cycle.
        ovf_d    = (wr_en & wr_full) | (wr_overflow & ~wr_ovf_clr);
    end

    always_ff @(posedge wr_clk or posedge wrst) begin
        if (wrst) begin
            wbin_q      <= '0;
            wptr        <= '0;
            wr_full     <= 1'b0;
            wr_afull    <= 1'b0;
            wr_level    <= '0;
            wr_room     <= PtrW'(Depth);
            wr_overflow <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr        <= wgray_d;
            wr_full     <= full_d;
            wr_afull    <= afull_d;
            wr_level    <= level_d;
            wr_room     <= room_d;
            wr_overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Scoreboard bench for wr_ptr_ctrl: a count-based FIFO model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_wr_ptr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          wr_clk;
    logic          wrst;
    logic          wr_en;
    logic [AW:0]   wq2_rptr;
    logic [AW:0]   wr_afull_thresh;
    logic          wr_ovf_clr;
    logic [AW-1:0] wr_addr;
    logic          wr_push;
    logic [AW:0]   wptr;
    logic          wr_full;
    logic          wr_afull;
    logic [AW:0]   wr_level;
    logic [AW:0]   wr_room;
    logic          wr_overflow;

    wr_ptr_ctrl #(
        .ADDRSIZE (AW)
    ) dut (
        .wr_clk          (wr_clk),
        .wrst            (wrst),
        .wr_en           (wr_en),
        .wq2_rptr        (wq2_rptr),
        .wr_afull_thresh (wr_afull_thresh),
        .wr_ovf_clr      (wr_ovf_clr),
        .wr_addr         (wr_addr),
        .wr_push         (wr_push),
        .wptr            (wptr),
        .wr_full         (wr_full),
        .wr_afull        (wr_afull),
        .wr_level        (wr_level),
        .wr_room         (wr_room),
        .wr_overflow     (wr_overflow)
    );

    typedef struct {
        int push;
        int addr;
        int wptr;
        int full;
        int afull;
        int level;
        int room;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: totals of accepted writes and of reads visible through wq2_rptr.
    int m_wcnt  = 0;
    int m_rcnt  = 0;
    int m_full  = 0;
    int m_afull = 0;
    int m_level = 0;
    int m_ovf   = 0;

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_wcnt  = 0;
        m_rcnt  = 0;
        m_full  = 0;
        m_afull = 0;
        m_level = 0;
        m_ovf   = 0;
    endtask

    // One write-clock cycle: inputs change 1 time unit after the edge (rst is asserted
    // asynchronously there too), the expected view for this cycle is queued, then the
    // model advances to the state the next edge should produce.
    task automatic drive(input int en, input int radv, input int clr, input int rst,
                         input int th);
        exp_t e;
        int   push;
        int   was_full;
        @(posedge wr_clk);
        #1;
        if (rst != 0) begin
            model_reset();
            wrst = 1'b1;
            en   = 0;
        end else begin
            wrst = 1'b0;
            if (radv > m_wcnt - m_rcnt) radv = m_wcnt - m_rcnt;
            m_rcnt += radv;
        end
        wr_en           = (en != 0);
        wr_ovf_clr      = (clr != 0);
        wq2_rptr        = (AW+1)'(gray(m_rcnt % PMOD));
        wr_afull_thresh = (AW+1)'(th);

        push    = (en != 0 && m_full == 0) ? 1 : 0;
        e.push  = push;
        e.addr  = m_wcnt % DEPTH;
        e.wptr  = gray(m_wcnt % PMOD);
        e.full  = m_full;
        e.afull = m_afull;
        e.level = m_level;
        e.room  = DEPTH - m_level;
        e.ovf   = m_ovf;
        sb_q.push_back(e);

        if (rst == 0) begin
            was_full = m_full;
            m_wcnt  += push;
            m_level  = m_wcnt - m_rcnt;
            m_full   = (m_level == DEPTH) ? 1 : 0;
            m_afull  = (m_level >= th) ? 1 : 0;
            m_ovf    = ((en != 0 && was_full != 0) || (m_ovf != 0 && clr == 0)) ? 1 : 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge wr_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("wr_push",     int'(wr_push),     e.push);
                check("wr_addr",     int'(wr_addr),     e.addr);
                check("wptr",        int'(wptr),        e.wptr);
                check("wr_full",     int'(wr_full),     e.full);
                check("wr_afull",    int'(wr_afull),    e.afull);
                check("wr_level",    int'(wr_level),    e.level);
                check("wr_room",     int'(wr_room),     e.room);
                check("wr_overflow", int'(wr_overflow), e.ovf);
            end
        end
    end

    initial begin : stimulus
        int th;
        wrst            = 1'b1;
        wr_en           = 1'b0;
        wr_ovf_clr      = 1'b0;
        wq2_rptr        = '0;
        wr_afull_thresh = (AW+1)'(DEPTH);

        // Fill with read pointer parked at 0, then overflow set/clear priority.
        repeat (2) drive(0, 0, 0, 1, DEPTH);
        repeat (20) drive(1, 0, 0, 0, DEPTH);
        drive(1, 0, 1, 0, DEPTH);
        drive(0, 0, 1, 0, DEPTH);
        drive(0, 0, 0, 0, DEPTH);

        // Almost-full at 12, then a two-entry read-pointer step.
        drive(0, 0, 0, 1, 12);
        repeat (12) drive(1, 0, 0, 0, 12);
        drive(0, 0, 0, 0, 12);
        drive(0, 2, 0, 0, 12);
        repeat (2) drive(0, 0, 0, 0, 12);

        // Wrap: 40 pushes with the read pointer trailing by one.
        drive(0, 0, 0, 1, DEPTH);
        drive(1, 0, 0, 0, DEPTH);
        repeat (39) drive(1, 1, 0, 0, DEPTH);
        drive(0, 0, 0, 0, DEPTH);
        drive(0, 1, 0, 0, DEPTH);

        // Asynchronous reset mid-burst at level 7, then first post-reset push.
        drive(0, 0, 0, 1, DEPTH);
        repeat (7) drive(1, 0, 0, 0, DEPTH);
        drive(1, 0, 0, 1, DEPTH);
        repeat (3) drive(1, 0, 0, 0, DEPTH);

        // Push and read-pointer advance together at level 15.
        drive(0, 0, 0, 1, DEPTH);
        repeat (15) drive(1, 0, 0, 0, DEPTH);
        repeat (3) drive(1, 1, 0, 0, DEPTH);
        drive(0, 0, 0, 0, DEPTH);

        // Threshold 0: almost-full from the first clock after reset.
        drive(0, 0, 0, 1, 0);
        repeat (2) drive(0, 0, 0, 0, 0);

        // Randomised traffic with occasional clears, resets and threshold changes.
        th = DEPTH;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) th = $urandom_range(0, DEPTH);
            drive(($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 299) == 0) ? 1 : 0,
                  th);
        end
        drive(0, 0, 0, 0, th);

        repeat (4) @(negedge wr_clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
Write-domain pointer and status controller for the asynchronous FIFO. It is the parametrised successor of the basic write-pointer/full block. It generates the binary memory write address and the Gray write pointer for the read-domain synchroniser, plus the registered full flag. New over the previous generation: fill level, remaining room, programmable almost-full, and sticky overflow detection with clear. It sits in the write clock domain between the FIFO write port, the dual-port RAM and the read-to-write pointer synchroniser.

Parameters:
ADDRSIZE, 4, RAM address width; DEPTH = 2**ADDRSIZE; legal range 2..16 (elaboration error otherwise).

Ports:
wr_clk  in  1  write-domain clock
wrst  in  1  asynchronous active-high reset
wr_en  in  1  write request
wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronised into wr_clk
wr_afull_thresh  in  ADDRSIZE+1  almost-full threshold in entries (0..DEPTH), quasi-static
wr_ovf_clr  in  1  clear sticky overflow
wr_addr  out  ADDRSIZE  binary RAM write address
wr_push  out  1  write accepted this cycle (RAM write enable)
wptr  out  ADDRSIZE+1  registered Gray write pointer
wr_full  out  1  registered full
wr_afull  out  1  registered almost-full
wr_level  out  ADDRSIZE+1  registered fill level, 0..DEPTH
wr_room  out  ADDRSIZE+1  registered free entries, DEPTH - wr_level
wr_overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (wrst high, asynchronous, immediate at any time including mid-burst): wbin, wptr, wr_full, wr_afull, wr_level, wr_overflow = 0; wr_room = DEPTH. Outputs hold these values while wrst is high.
- wr_push = wr_en & ~wr_full (combinational). wr_addr = wbin[ADDRSIZE-1:0].
- wbinnext = wbin + wr_push, modulo 2**(ADDRSIZE+1). wgraynext = (wbinnext>>1) ^ wbinnext. Both register on every wr_clk edge.
- Full: wr_full <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). Full is high the cycle after the DEPTH-th unread write is accepted. Deassertion lags reads by synchroniser latency plus 1 cycle (pessimistic, safe).
- Level: rbin = gray2bin(wq2_rptr); wr_level <= wbinnext - rbin, computed modulo 2**(ADDRSIZE+1). Result never exceeds DEPTH. The level is pessimistic (stale read pointer) and never under-reports.
- wr_room <= DEPTH - level_next, computed in the same cycle as wr_level.
- Almost-full: wr_afull <= (level_next >= wr_afull_thresh). Threshold 0 gives constant 1 after the first clock. Threshold DEPTH makes wr_afull track wr_full.
- Overflow: set when wr_en & wr_full; cleared by wr_ovf_clr. Set wins over a simultaneous clear. Dropped writes do not advance pointers.
- Wrap-around: the pointer MSB toggles every DEPTH writes. Full and level stay correct across any number of wraps.
- wq2_rptr changing in the same cycle as a push: both are used in the same next-state computation, with no special case.

Decomposition:
- Package async_fifo_pkg holds the functions bin2gray and gray2bin. They are parametrised via width-generic loops sized by ADDRSIZE+1 max, or via a parameterised class static function.
- Package async_fifo_pkg also holds a shared localparam helper for DEPTH.
- One natural sub-module: gray2bin_conv, a combinational XOR prefix converter. It is reused by the read-side counterpart for the write pointer.
- Everything else stays flat in wr_ptr_ctrl.

Test Plan:
- ADDRSIZE=4, wq2_rptr held 0, wr_en=1 for 20 cycles -> exactly 16 wr_push pulses; wr_addr 0..15. wr_full=1 from the cycle after the 16th push. wptr=5'b11000. wr_level=16, wr_room=0. wr_overflow=1 after the first blocked write.
- Continue the first test; assert wr_ovf_clr and wr_en together while full -> wr_overflow stays 1. Next cycle, wr_ovf_clr only -> wr_overflow=0.
- wr_afull_thresh=12, 12 writes with rptr 0 -> wr_afull rises the cycle after the 12th push, with wr_level=12. Then step wq2_rptr to Gray(2)=5'b00011 -> wr_level=10, wr_afull=0 next cycle.
- Wrap: alternate a write with a matching rptr Gray update for 40 pushes -> wr_level stays at 1, wr_full never asserts, and wptr equals bin2gray(40 mod 32)=bin2gray(8)=5'b01100.
- wrst pulsed high mid-burst, asynchronous between edges at level 7 -> all outputs at reset values immediately: wr_room=16, wptr=0. The first post-reset push writes wr_addr=0.
- Simultaneous push and rptr advance at full-minus-one (level 15) -> level stays 15 and wr_full stays 0.
